// File: rtl/rv_pkg.sv
// Shared definitions for the instruction-fetch front end: FSM encoding,
// the canonical nop word and the default reset vector.
package rv_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    FAULT = 2'd2
  } fetch_state_e;

  // addi x0, x0, 0
  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/pcnext_sel.sv
// Next-PC selection: sequential PC+4, branch/jal target, or jalr target with
// its LSB forced to zero, plus a flag for targets that are not word aligned.
module pcnext_sel
  import rv_pkg::*;
(
  input  logic [XLEN-1:0] pc,
  input  logic            pc_src,
  input  logic            pc_result_src,
  input  logic [XLEN-1:0] pc_target,
  input  logic [XLEN-1:0] alu_result,
  output logic [XLEN-1:0] pc_plus4,
  output logic [XLEN-1:0] next_pc,
  output logic            misaligned
);

  // Pick the successor PC and flag any target that is not word aligned.
  always_comb begin
    pc_plus4 = pc + 32'd4;
    next_pc  = pc_plus4;
    if (pc_src) begin
      if (pc_result_src) begin
        next_pc = {alu_result[XLEN-1:1], 1'b0};
      end else begin
        next_pc = pc_target;
      end
    end
    misaligned = |next_pc[1:0];
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: holds the PC, fetches from a variable-latency
// instruction memory, presents each instruction for exactly one execute
// cycle, traps on misaligned targets and counts retired instructions.
module fetch_unit
  import rv_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter int          INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 PCSrc,
  input  logic                 PCResultSrc,
  input  logic [31:0]          PCTarget,
  input  logic [31:0]          ALUResult,
  output logic                 imem_req,
  output logic [31:0]          imem_addr,
  input  logic [31:0]          imem_rdata,
  input  logic                 imem_valid,
  output logic [31:0]          Instr,
  output logic [31:0]          PC,
  output logic [31:0]          PCPlus4,
  output logic                 InstrValid,
  output logic                 Fault,
  output logic [31:0]          FaultPC,
  output logic [INSTRET_W-1:0] InstRet
);

  fetch_state_e         state_q, state_d;
  logic [31:0]          pc_q, pc_d;
  logic [31:0]          instr_q, instr_d;
  logic                 fault_q, fault_d;
  logic [31:0]          fault_pc_q, fault_pc_d;
  logic [INSTRET_W-1:0] instret_q, instret_d;

  logic [31:0] next_pc;
  logic [31:0] pc_plus4;
  logic        misaligned;

  pcnext_sel u_pcnext_sel (
    .pc            (pc_q),
    .pc_src        (PCSrc),
    .pc_result_src (PCResultSrc),
    .pc_target     (PCTarget),
    .alu_result    (ALUResult),
    .pc_plus4      (pc_plus4),
    .next_pc       (next_pc),
    .misaligned    (misaligned)
  );

  // Next-state and output logic: wait for the fetch, execute for one cycle,
  // then either fetch the successor or park in FAULT until reset.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    fault_d    = fault_q;
    fault_pc_d = fault_pc_q;
    instret_d  = instret_q;
    imem_req   = 1'b0;
    InstrValid = 1'b0;
    case (state_q)
      FETCH: begin
        imem_req = 1'b1;
        if (imem_valid) begin
          instr_d = imem_rdata;
          state_d = EXEC;
        end
      end
      EXEC: begin
        InstrValid = 1'b1;
        pc_d       = next_pc;
        instret_d  = instret_q + INSTRET_W'(1);
        if (misaligned) begin
          // The faulting instruction still retires and the PC still moves,
          // so FaultPC and PC both show the offending target.
          state_d    = FAULT;
          fault_d    = 1'b1;
          fault_pc_d = next_pc;
        end else begin
          state_d = FETCH;
        end
      end
      FAULT: begin
        state_d = FAULT;
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  // State registers; reset restores the whole front end, dropping any
  // in-flight instruction without counting it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= FETCH;
      pc_q       <= RESET_PC;
      instr_q    <= NOP_INSTR;
      fault_q    <= 1'b0;
      fault_pc_q <= '0;
      instret_q  <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      fault_q    <= fault_d;
      fault_pc_q <= fault_pc_d;
      instret_q  <= instret_d;
    end
  end

  assign imem_addr = pc_q;
  assign PC        = pc_q;
  assign PCPlus4   = pc_plus4;
  assign Instr     = instr_q;
  assign Fault     = fault_q;
  assign FaultPC   = fault_pc_q;
  assign InstRet   = instret_q;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the controller and datapath in the RISC-V core.
- Holds the PC and issues a request/valid fetch to instruction memory. Latches the returned word into an instruction register, which drives op, funct3 and funct7b5 into the controller.
- Consumes the controller's PCSrc/PCResultSrc plus datapath targets to select the next PC. Tolerates variable-latency memory, traps misaligned targets and counts retired instructions.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- INSTRET_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; sampled on the rising edge of clk.
- PCSrc  in  1  from controller; 1 = take branch/jump target.
- PCResultSrc  in  1  from controller; 0 = PCTarget (branch/jal), 1 = ALUResult (jalr).
- PCTarget  in  32  PC+imm from datapath.
- ALUResult  in  32  rs1+imm from datapath (jalr).
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address.
- imem_rdata  in  32  fetched word; valid only when imem_valid=1.
- imem_valid  in  1  response strobe.
- Instr  out  32  instruction register.
- PC  out  32  address of Instr.
- PCPlus4  out  32  PC+4.
- InstrValid  out  1  Instr is executing this cycle; datapath qualifies RegWrite/MemWrite with it.
- Fault  out  1  sticky misaligned-target trap.
- FaultPC  out  32  offending target address.
- InstRet  out  INSTRET_W  retired-instruction count.

Behaviour:
- Reset values: state=FETCH, PC=RESET_PC, Instr=32'h0000_0013 (nop), InstrValid=0, Fault=0, FaultPC=0, InstRet=0. imem_req=1 in the first cycle after reset.
- FETCH state:
  - imem_req=1, imem_addr=PC; both held stable until imem_valid.
  - On imem_valid: Instr<=imem_rdata, go to EXEC.
  - imem_valid in the same cycle as the request is legal (zero-wait).
- EXEC state (exactly one cycle):
  - InstrValid=1, imem_req=0.
  - At the clock edge: PC<=NextPC, InstRet<=InstRet+1 (wraps modulo 2^INSTRET_W).
  - If NextPC[1:0]==0, go to FETCH.
  - Otherwise go to FAULT, set Fault=1, FaultPC<=NextPC. PC is still updated; the instruction is still counted as retired.
- FAULT state: imem_req=0, InstrValid=0, Instr held. Exit only through reset.
- NextPC, combinational:
  - PCSrc=0 -> PCPlus4.
  - PCSrc=1, PCResultSrc=0 -> PCTarget.
  - PCSrc=1, PCResultSrc=1 -> {ALUResult[31:1],1'b0} (jalr LSB clear).
- PCPlus4 = PC+4, modulo 2^32. PC=32'hFFFF_FFFC sequential -> 0, no fault.
- Throughput: zero-wait memory gives 2 cycles per instruction; each memory wait cycle adds 1.
- imem_valid outside FETCH is ignored; no outstanding-request tracking.
- Reset mid-fetch or mid-EXEC: all state returns to reset values on that edge; no retire is counted for the interrupted instruction.
- PCSrc/PCResultSrc/targets are sampled only in EXEC.

Decomposition:
- Shared package rv_pkg: state encoding (FETCH, EXEC, FAULT), NOP constant 32'h0000_0013, default RESET_PC.
- One combinational sub-module, pcnext_sel: the next-PC mux plus PC+4 and the alignment check.
- FSM, registers and counter stay in fetch_unit.

Test Plan:
- Reset, zero-wait memory returning 32'h00500093 at 0 -> imem_addr=0 in cycle 1; InstrValid=1 in cycle 2; PC=4 and InstRet=1 in cycle 3.
- 3-cycle memory latency -> imem_addr held at 0 for 3 cycles, InstrValid stays 0 until the response, then exactly one InstrValid pulse.
- In EXEC at PC=0x10 with PCSrc=1, PCResultSrc=0, PCTarget=0x40 -> next imem_addr=0x40.
- jalr: PCSrc=1, PCResultSrc=1, ALUResult=0x81 -> next PC=0x80, no fault.
- PCTarget=0x42 taken -> Fault=1, FaultPC=0x42, imem_req=0 thereafter until reset; reset clears Fault and PC=RESET_PC.
- Assert reset while waiting on memory at PC=0x20 -> next cycle PC=RESET_PC, InstRet unchanged from 0, imem_addr=RESET_PC.
